// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // LO after a divide by zero is all ones, whatever the operand width.
  localparam logic DIV_ZERO_LO_FILL = 1'b1;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per enabled cycle.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
    end else if (en) begin
      // Partial remainder stays below the divisor, so trial[WIDTH] is a clean borrow.
      if (!trial[WIDTH]) begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quot_q <= quot_d;
    dvs_q  <= dvs_d;
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO.
// Optional MDU_FAST_MUL_EN: mult/multu use a single-cycle array multiply.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic             Start,
  input  logic [2:0]       MD_Op,
  input  logic [WIDTH-1:0] In_1,
  input  logic [WIDTH-1:0] In_2,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] mul_q, mul_d, prod_fix;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d, b_zero_q, b_zero_d;

  logic               accept, div_load, div_en;
  logic [WIDTH-1:0]   mag_a, mag_b, quot, rem, res_hi, res_lo;
  logic [WIDTH:0]     step_sum;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept = Start && (state_q == ST_IDLE);
  assign mag_a  = magnitude(In_1, is_signed_op(MD_Op));
  assign mag_b  = magnitude(In_2, is_signed_op(MD_Op));

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (Clk),
    .load     (div_load),
    .en       (div_en),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (quot),
    .rem      (rem)
  );

  // Operand capture and shift-add multiply: {acc, multiplier} shifts right each step.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    mcand_d   = mcand_q;
    mul_d     = mul_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    step_sum  = {1'b0, mul_q[2*WIDTH-1:WIDTH]} + (mul_q[0] ? {1'b0, mcand_q} : '0);
    if (accept) begin
      op_d      = MD_Op;
      a_d       = In_1;
      mcand_d   = mag_a;
      neg_d     = is_signed_op(MD_Op) && (In_1[WIDTH-1] ^ In_2[WIDTH-1]);
      rem_neg_d = (MD_Op == MD_DIV) && In_1[WIDTH-1];
      b_zero_d  = (In_2 == '0);
`ifdef MDU_FAST_MUL_EN
      mul_d     = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
      mul_d     = {{WIDTH{1'b0}}, mag_b};
`endif
    end else if ((state_q == ST_CALC) && is_mul(op_q)) begin
      mul_d = {step_sum, mul_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude results, applied in the FIX cycle.
  always_comb begin
    prod_fix = neg_q ? -mul_q : mul_q;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (!is_mul(op_q)) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = {WIDTH{DIV_ZERO_LO_FILL}};
      end else begin
        res_lo = neg_q ? -quot : quot;
        res_hi = rem_neg_q ? -rem : rem;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_load   = 1'b0;
    div_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          div_zero_d = 1'b0;
          if (is_mul(MD_Op)) begin
`ifdef MDU_FAST_MUL_EN
            state_d = ST_FIX;
`else
            state_d = ST_CALC;
            cnt_d   = CNT_W'(WIDTH - 1);
`endif
          end else if (is_div(MD_Op)) begin
            state_d  = ST_CALC;
            cnt_d    = CNT_W'(WIDTH - 1);
            div_load = 1'b1;
          end else begin
            done_d = 1'b1;
            if (MD_Op == MD_MTHI) hi_d = In_1;
            if (MD_Op == MD_MTLO) lo_d = In_1;
          end
        end
      end
      ST_CALC: begin
        div_en = is_div(op_q);
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        hi_d    = res_hi;
        lo_d    = res_lo;
        if (is_div(op_q)) div_zero_d = b_zero_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_ff @(posedge Clk) begin
    op_q      <= op_d;
    a_q       <= a_d;
    mcand_q   <= mcand_d;
    mul_q     <= mul_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    b_zero_q  <= b_zero_d;
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Done     = done_q;
  assign Div_Zero = div_zero_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] in1, in2;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(clk), .Rst_N(rst_n), .Start(start), .MD_Op(md_op), .In_1(in1), .In_2(in2),
    .Busy(busy), .Done(done), .Div_Zero(div_zero), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          free_edge = 0;
  int          last_acc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic, division truncating toward zero.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t x, output int lat);
    longint      sa, sb_, q, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_  = longint'($signed(b));
    x.hi = m_hi;
    x.lo = m_lo;
    x.dz = 1'b0;
    lat  = 1;
    case (op)
      3'd0: begin p = sa * sb_; x.hi = p[63:32]; x.lo = p[31:0]; lat = MUL_LAT; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; x.hi = p[63:32]; x.lo = p[31:0]; lat = MUL_LAT; end
      3'd2, 3'd3: begin
        lat = DIV_LAT;
        if (b == 0) begin
          x.hi = a; x.lo = 32'hFFFF_FFFF; x.dz = 1'b1;
        end else if (op == 3'd2) begin
          q = sa / sb_; r = sa % sb_;
          x.lo = q[31:0]; x.hi = r[31:0];
        end else begin
          x.lo = a / b; x.hi = a % b;
        end
      end
      3'd4: x.hi = a;
      3'd5: x.lo = a;
      default: ;
    endcase
    m_hi = x.hi;
    m_lo = x.lo;
  endtask

  task automatic issue(input bit sync, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    int   e, lat;
    if (sync) @(negedge clk);
    start = 1'b1; md_op = op; in1 = a; in2 = b;
    e = cyc + 1;
    if (e >= free_edge) begin
      model(op, a, b, x, lat);
      x.due     = e + lat - 1;
      last_acc  = e;
      free_edge = e + lat;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    start = 1'b0; md_op = 3'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_free();
    @(negedge clk);
    while (cyc < free_edge) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      chk("busy", {63'b0, busy}, {63'b0, (cyc >= last_acc) && (cyc <= free_edge - 2)});
      while (sb.size() > 0 && sb[0].due < cyc) begin
        total++; bad++;
        $display("FAIL done_missing: no Done, expected at cycle %0d (now %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL done_spurious: Done=1 at cycle %0d, expected no Done", cyc);
        end else begin
          x = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(x.due));
          chk("hi", {32'b0, hi}, {32'b0, x.hi});
          chk("lo", {32'b0, lo}, {32'b0, x.lo});
          chk("div_zero", {63'b0, div_zero}, {63'b0, x.dz});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = '0; in1 = '0; in2 = '0;
    #12;
    chk("rst_hi", {32'b0, hi}, 64'h0);
    chk("rst_lo", {32'b0, lo}, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_done", {63'b0, done}, 64'h0);
    chk("rst_dz", {63'b0, div_zero}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_free();
    issue(1, 3'd0, 32'hFFFF_FFF9, 32'd3);         wait_free();
    issue(1, 3'd2, 32'hFFFF_FFF9, 32'd2);         wait_free();
    issue(1, 3'd3, 32'd7, 32'd0);                 wait_free();
    issue(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_free();
    issue(1, 3'd0, 32'd0, 32'h1234_5678);         wait_free();
    issue(1, 3'd4, 32'h1234, 32'd0);
    issue(1, 3'd5, 32'h5678, 32'd0);              wait_free();

    // Start mid-divide is dropped; Start in the Done cycle is taken.
    issue(1, 3'd3, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    issue(0, 3'd1, 32'd9, 32'd9);
    @(negedge clk);
    while (cyc < free_edge - 1) @(negedge clk);
    issue(0, 3'd2, 32'hFFFF_FF00, 32'd5);
    wait_free();

    // Reset in the middle of a multiply.
    issue(1, 3'd0, 32'd5, 32'd6);
    @(negedge clk);
    while (cyc < last_acc + 14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete(); free_edge = 0; last_acc = 0; m_hi = '0; m_lo = '0;
    #1;
    chk("midrst_hi", {32'b0, hi}, 64'h0);
    chk("midrst_lo", {32'b0, lo}, 64'h0);
    chk("midrst_busy", {63'b0, busy}, 64'h0);
    chk("midrst_done", {63'b0, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 3'd1, 32'd3, 32'd5); wait_free();

    for (int i = 0; i < 60; i++) begin
      issue(1, 3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_free();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
